// File: rtl/l2_mem_bridge_if.sv
// L2-side line port and external memory-bus port of the L2 memory bridge.
// master drives requests/commands; slave answers them.
interface l2_port_if;
    logic [47:0]  l2_addr;
    logic         l2_read;
    logic         l2_write;
    logic [511:0] l2_write_data;
    logic [511:0] l2_read_data;
    logic         l2_ready;
    logic         mem_err;

    modport master (output l2_addr, l2_read, l2_write, l2_write_data,
                    input  l2_read_data, l2_ready, mem_err);
    modport slave  (input  l2_addr, l2_read, l2_write, l2_write_data,
                    output l2_read_data, l2_ready, mem_err);
endinterface

interface mem_bus_if #(parameter int BEAT_W = 64);
    logic              bus_cmd_valid;
    logic              bus_cmd_ready;
    logic              bus_cmd_write;
    logic [47:0]       bus_cmd_addr;
    logic [BEAT_W-1:0] bus_wdata;
    logic              bus_wvalid;
    logic              bus_wready;
    logic [BEAT_W-1:0] bus_rdata;
    logic              bus_rvalid;

    modport master (output bus_cmd_valid, bus_cmd_write, bus_cmd_addr, bus_wdata, bus_wvalid,
                    input  bus_cmd_ready, bus_wready, bus_rdata, bus_rvalid);
    modport slave  (input  bus_cmd_valid, bus_cmd_write, bus_cmd_addr, bus_wdata, bus_wvalid,
                    output bus_cmd_ready, bus_wready, bus_rdata, bus_rvalid);
endinterface

// File: rtl/l2_mem_bridge.sv
// Serializes one 512-bit L2 line fetch/writeback into a command plus BEATS data beats.
// Optional stall watchdog enabled by defining L2MEM_TIMEOUT_EN.
module l2_mem_bridge #(
    parameter int BEAT_W         = 64,
    parameter int BEATS          = 512 / BEAT_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic      clk,
    input  logic      reset,
    l2_port_if.slave  l2,
    mem_bus_if.master bus
);
    localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, RESP} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [47:0]   addr_q, addr_d;
    logic [511:0]  wbuf_q, wbuf_d, rline_q, rline_d;
    logic          wr_q, wr_d;
    logic          ready_q;
    logic          last_beat;

    assign last_beat = (k_q == KW'(BEATS - 1));

`ifdef L2MEM_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    logic        err_q, err_d;
    logic        active, progress;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        rline_d = rline_q;
        wr_d    = wr_q;
`ifdef L2MEM_TIMEOUT_EN
        stall_d  = stall_q;
        err_d    = err_q;
        active   = 1'b0;
        progress = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (l2.l2_write) begin
                    addr_d  = {l2.l2_addr[47:6], 6'b0};
                    wbuf_d  = l2.l2_write_data;
                    wr_d    = 1'b1;
                    state_d = CMD;
                end else if (l2.l2_read) begin
                    addr_d  = {l2.l2_addr[47:6], 6'b0};
                    wr_d    = 1'b0;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (bus.bus_cmd_ready) begin
                    k_d     = '0;
                    state_d = wr_q ? WDATA : RDATA;
                    // Start from a clean line so beats lost to a timeout read as zero.
                    if (!wr_q) rline_d = '0;
                end
            end
            WDATA: begin
                if (bus.bus_wready) begin
                    k_d = k_q + 1'b1;
                    if (last_beat) state_d = RESP;
                end
            end
            RDATA: begin
                if (bus.bus_rvalid) begin
                    rline_d[k_q*BEAT_W +: BEAT_W] = bus.bus_rdata;
                    k_d = k_q + 1'b1;
                    if (last_beat) state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef L2MEM_TIMEOUT_EN
        active   = (state_q == CMD) || (state_q == WDATA) || (state_q == RDATA);
        progress = ((state_q == CMD)   && bus.bus_cmd_ready) ||
                   ((state_q == WDATA) && bus.bus_wready)    ||
                   ((state_q == RDATA) && bus.bus_rvalid);
        if (!active || progress) begin
            stall_d = '0;
        end else begin
            stall_d = stall_q + 16'd1;
            if (stall_d == 16'(TIMEOUT_CYCLES)) begin
                state_d = RESP;
                err_d   = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rline_q <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            rline_q <= rline_d;
            wr_q    <= wr_d;
            ready_q <= (state_d == RESP);
        end
    end

`ifdef L2MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end
    assign l2.mem_err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^32'(TIMEOUT_CYCLES);
    assign l2.mem_err = 1'b0;
`endif

    // Low address bits only select bytes within the line.
    logic unused_lo;
    assign unused_lo = ^l2.l2_addr[5:0];

    assign l2.l2_ready     = ready_q;
    assign l2.l2_read_data = rline_q;

    assign bus.bus_cmd_valid = (state_q == CMD);
    assign bus.bus_cmd_write = (state_q == CMD) && wr_q;
    assign bus.bus_cmd_addr  = addr_q;
    assign bus.bus_wvalid    = (state_q == WDATA);
    assign bus.bus_wdata     = (state_q == WDATA) ? wbuf_q[k_q*BEAT_W +: BEAT_W] : '0;
endmodule

// File: tb/tb_l2_mem_bridge.sv
// Directed bench for l2_mem_bridge: a reactive bus model drives beats, tasks check results.
module tb_l2_mem_bridge;
    localparam int BW = 64;
    localparam int NB = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [47:0] got_addr;
    logic        got_write;
    int          cmd_cyc;
    logic [63:0] got_w[$];

    l2_port_if             l2i();
    mem_bus_if #(.BEAT_W(BW)) busi();

    l2_mem_bridge #(.BEAT_W(BW), .BEATS(NB), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .l2(l2i), .bus(busi)
    );

    always #5 clk = ~clk;

    // Caller must be at a negedge. Request is driven now (cycle 0); lat is the cycle of
    // l2_ready, or -1 if the budget runs out or the transfer is aborted with reset.
    task automatic run_txn(input logic wr, input logic [47:0] addr, input logic [511:0] wline,
                           input int cmd_stall, input logic [31:0] wpat, input int rstop,
                           input int abort_at, input logic [63:0] rbase, output int lat);
        int cyc, cw, wi, rk;
        logic rd_phase;
        cyc = 0; cw = 0; wi = 0; rk = 0; rd_phase = 1'b0; lat = -1;
        cmd_cyc = -1; got_addr = 'x; got_write = 1'bx; got_w.delete();
        l2i.l2_addr = addr; l2i.l2_write_data = wline;
        l2i.l2_write = wr; l2i.l2_read = !wr;
        while (cyc < 100) begin
            @(posedge clk); @(negedge clk); cyc++;
            busi.bus_cmd_ready = 1'b0; busi.bus_wready = 1'b0;
            busi.bus_rvalid = 1'b0;    busi.bus_rdata = '0;
            if (l2i.l2_ready) begin
                lat = cyc; l2i.l2_read = 1'b0; l2i.l2_write = 1'b0;
                return;
            end
            if (rd_phase && abort_at >= 0 && rk == abort_at) begin
                reset = 1'b1; #1;
                l2i.l2_read = 1'b0; l2i.l2_write = 1'b0;
                return;
            end
            if (rd_phase && rk < rstop && rk < NB) begin
                busi.bus_rvalid = 1'b1; busi.bus_rdata = rbase + 64'(rk); rk++;
            end
            if (busi.bus_cmd_valid) begin
                if (cw == 0) begin
                    got_addr = busi.bus_cmd_addr; got_write = busi.bus_cmd_write; cmd_cyc = cyc;
                    // Request is captured by now; scramble it to prove it is not re-read.
                    l2i.l2_addr = ~addr; l2i.l2_write_data = ~wline;
                end
                if (cw >= cmd_stall) begin
                    busi.bus_cmd_ready = 1'b1; rd_phase = !busi.bus_cmd_write;
                end
                cw++;
            end
            if (busi.bus_wvalid) begin
                busi.bus_wready = (wi < 32) ? wpat[wi] : 1'b1;
                if (busi.bus_wready) got_w.push_back(busi.bus_wdata);
                wi++;
            end
        end
        l2i.l2_read = 1'b0; l2i.l2_write = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        l2i.l2_addr = '0; l2i.l2_read = 1'b0; l2i.l2_write = 1'b0; l2i.l2_write_data = '0;
        busi.bus_cmd_ready = 1'b0; busi.bus_wready = 1'b0; busi.bus_rvalid = 1'b0; busi.bus_rdata = '0;
        repeat (2) @(negedge clk);
        checks++; if (l2i.l2_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", l2i.l2_ready); end
        checks++; if (l2i.l2_read_data !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", l2i.l2_read_data); end
        checks++; if (busi.bus_cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid: got %b want 0", busi.bus_cmd_valid); end
        checks++; if (busi.bus_cmd_addr !== 48'h0) begin errors++; $display("FAIL rst_cmd_addr: got %h want 0", busi.bus_cmd_addr); end
        checks++; if (busi.bus_wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid: got %b want 0", busi.bus_wvalid); end
        checks++; if (l2i.mem_err !== 1'b0) begin errors++; $display("FAIL rst_mem_err: got %b want 0", l2i.mem_err); end
        reset = 1'b0;
    endtask

    task automatic test_read_line;
        int lat;
        run_txn(1'b0, 48'h0000_0000_1240, '0, 0, '1, NB, -1, 64'h0, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL rd_lat: got %0d want 10", lat); end
        checks++; if (cmd_cyc !== 1) begin errors++; $display("FAIL rd_cmd_cyc: got %0d want 1", cmd_cyc); end
        checks++; if (got_addr !== 48'h1240) begin errors++; $display("FAIL rd_cmd_addr: got %h want 1240", got_addr); end
        checks++; if (got_write !== 1'b0) begin errors++; $display("FAIL rd_cmd_write: got %b want 0", got_write); end
        checks++; if (l2i.l2_read_data[63:0] !== 64'h0) begin errors++; $display("FAIL rd_beat0: got %h want 0", l2i.l2_read_data[63:0]); end
        checks++; if (l2i.l2_read_data[511:448] !== 64'h7) begin errors++; $display("FAIL rd_beat7: got %h want 7", l2i.l2_read_data[511:448]); end
        @(negedge clk);
        checks++; if (l2i.l2_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_pulse: got %b want 0", l2i.l2_ready); end
    endtask

    task automatic test_wb_then_fetch;
        int lat;
        logic [511:0] wl;
        for (int k = 0; k < NB; k++) wl[k*BW +: BW] = 64'hA0 + 64'(k);
        run_txn(1'b1, 48'h2000, wl, 0, '1, NB, -1, 64'h0, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL wb_lat: got %0d want 10", lat); end
        checks++; if (got_write !== 1'b1) begin errors++; $display("FAIL wb_cmd_write: got %b want 1", got_write); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (got_w[k] !== 64'hA0 + 64'(k)) begin errors++; $display("FAIL wb_beat%0d: got %h want %h", k, got_w[k], 64'hA0 + 64'(k)); end
        end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (l2i.l2_read_data[k*BW +: BW] !== 64'(k)) begin errors++; $display("FAIL wb_rdata_hold%0d: got %h want %h", k, l2i.l2_read_data[k*BW +: BW], 64'(k)); end
        end
        // Fetch raised in the write's l2_ready cycle: RESP->IDLE, IDLE samples, CMD next.
        run_txn(1'b0, 48'h2000, '0, 0, '1, NB, -1, 64'h100, lat);
        checks++; if (cmd_cyc !== 2) begin errors++; $display("FAIL fetch_cmd_cyc: got %0d want 2", cmd_cyc); end
        checks++; if (lat !== 11) begin errors++; $display("FAIL fetch_lat: got %0d want 11", lat); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (l2i.l2_read_data[k*BW +: BW] !== 64'h100 + 64'(k)) begin errors++; $display("FAIL fetch_beat%0d: got %h want %h", k, l2i.l2_read_data[k*BW +: BW], 64'h100 + 64'(k)); end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [511:0] wl;
        for (int k = 0; k < NB; k++) wl[k*BW +: BW] = 64'hC0DE_0000_0000_0000 | 64'(k);
        // wready per presented cycle (lsb first): 1,0,1,0,1,0,1,0,1,1,1,1 -> 4 stalls.
        run_txn(1'b1, 48'h3000, wl, 3, 32'h0000_0F55, NB, -1, 64'h0, lat);
        checks++; if (lat !== 17) begin errors++; $display("FAIL bp_lat: got %0d want 17", lat); end
        checks++; if (got_w.size() !== NB) begin errors++; $display("FAIL bp_nbeats: got %0d want %0d", got_w.size(), NB); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (got_w[k] !== (64'hC0DE_0000_0000_0000 | 64'(k))) begin errors++; $display("FAIL bp_beat%0d: got %h want %h", k, got_w[k], 64'hC0DE_0000_0000_0000 | 64'(k)); end
        end
    endtask

    task automatic test_capture;
        int lat;
        logic [511:0] wl;
        for (int k = 0; k < NB; k++) wl[k*BW +: BW] = 64'h5A5A_0000 + 64'(k * 3);
        @(negedge clk);
        run_txn(1'b1, 48'h1267, wl, 0, '1, NB, -1, 64'h0, lat);
        checks++; if (got_addr !== 48'h1240) begin errors++; $display("FAIL cap_addr: got %h want 1240", got_addr); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL cap_lat: got %0d want 10", lat); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (got_w[k] !== 64'h5A5A_0000 + 64'(k * 3)) begin errors++; $display("FAIL cap_beat%0d: got %h want %h", k, got_w[k], 64'h5A5A_0000 + 64'(k * 3)); end
        end
    endtask

    task automatic test_ignored_inputs;
        @(negedge clk);
        busi.bus_rvalid = 1'b1; busi.bus_rdata = '1; busi.bus_wready = 1'b1; busi.bus_cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busi.bus_cmd_valid !== 1'b0 || busi.bus_wvalid !== 1'b0) begin errors++; $display("FAIL ign_bus: got cmd_valid %b wvalid %b want 0 0", busi.bus_cmd_valid, busi.bus_wvalid); end
        checks++; if (l2i.l2_read_data[BW-1:0] !== 64'h100) begin errors++; $display("FAIL ign_rdata: got %h want 100", l2i.l2_read_data[BW-1:0]); end
        busi.bus_rvalid = 1'b0; busi.bus_rdata = '0; busi.bus_wready = 1'b0; busi.bus_cmd_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat;
        run_txn(1'b0, 48'h4000, '0, 0, '1, NB, 4, 64'h200, lat);
        checks++; if (lat !== -1) begin errors++; $display("FAIL rmid_no_ready: got lat %0d want -1", lat); end
        checks++; if (l2i.l2_read_data !== '0) begin errors++; $display("FAIL rmid_rdata: got %h want 0", l2i.l2_read_data); end
        checks++; if (busi.bus_cmd_valid !== 1'b0 || busi.bus_cmd_addr !== 48'h0) begin errors++; $display("FAIL rmid_cmd: got valid %b addr %h want 0 0", busi.bus_cmd_valid, busi.bus_cmd_addr); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (l2i.l2_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b want 0", l2i.l2_ready); end
        end
        reset = 1'b0;
        run_txn(1'b0, 48'h4000, '0, 0, '1, NB, -1, 64'h300, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL rmid_next_lat: got %0d want 10", lat); end
        checks++; if (l2i.l2_read_data[511:448] !== 64'h307) begin errors++; $display("FAIL rmid_next_beat7: got %h want 307", l2i.l2_read_data[511:448]); end
    endtask

`ifdef L2MEM_TIMEOUT_EN
    task automatic test_timeout;
        int lat;
        @(negedge clk);
        // Beats at 2..4; stall counter reaches 16 on the edge ending cycle 20 -> l2_ready at 21.
        run_txn(1'b0, 48'h5000, '0, 0, '1, 3, -1, 64'h400, lat);
        checks++; if (lat !== 21) begin errors++; $display("FAIL to_lat: got %0d want 21", lat); end
        checks++; if (l2i.mem_err !== 1'b1) begin errors++; $display("FAIL to_mem_err: got %b want 1", l2i.mem_err); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (l2i.l2_read_data[k*BW +: BW] !== ((k < 3) ? 64'h400 + 64'(k) : 64'h0)) begin errors++; $display("FAIL to_beat%0d: got %h", k, l2i.l2_read_data[k*BW +: BW]); end
        end
        repeat (5) @(negedge clk);
        checks++; if (l2i.mem_err !== 1'b1) begin errors++; $display("FAIL to_mem_err_hold: got %b want 1", l2i.mem_err); end
    endtask
`else
    task automatic test_no_timeout;
        checks++; if (l2i.mem_err !== 1'b0) begin errors++; $display("FAIL mem_err_tied: got %b want 0", l2i.mem_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_read_line();
        test_wb_then_fetch();
        test_ignored_inputs();
        test_backpressure();
        test_capture();
        test_reset_mid();
`ifdef L2MEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
